// File: rtl/spi_pkg.sv
// Shared state encoding, command codes and bit-order helper for the SPI slave.
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StChkCmd   = 3'd1;
  localparam state_t StWrite    = 3'd2;
  localparam state_t StReadAdd  = 3'd3;
  localparam state_t StReadData = 3'd4;
  localparam state_t StRdWait   = 3'd5;
  localparam state_t StRdSend   = 3'd6;
  localparam state_t StDone     = 3'd7;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Data-word bit index carried by the i-th serial payload bit.
  function automatic int unsigned bit_idx(input int unsigned i, input int unsigned width,
                                          input bit lsb_first);
    return lsb_first ? i : width - 1 - i;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load MISO serialiser: first bit appears the cycle after load, one bit per shift.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              miso_o,
  output logic              done_o
);

  localparam int unsigned RemW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] ord;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic              miso_q, miso_d;

  // Reorder so the word always leaves from the top bit.
  for (genvar g = 0; g < DATA_W; g++) begin : g_ord
    assign ord[DATA_W-1-g] = data_i[bit_idx(g, DATA_W, LSB_FIRST)];
  end

  always_comb begin
    sh_d   = sh_q;
    rem_d  = rem_q;
    miso_d = miso_q;
    done_o = 1'b0;
    if (clr_i) begin
      sh_d   = '0;
      rem_d  = '0;
      miso_d = 1'b0;
    end else if (load_i) begin
      miso_d = ord[DATA_W-1];
      sh_d   = ord << 1;
      rem_d  = RemW'(DATA_W - 1);
    end else if (shift_i) begin
      if (rem_q != '0) begin
        miso_d = sh_q[DATA_W-1];
        sh_d   = sh_q << 1;
        rem_d  = rem_q - RemW'(1);
      end else begin
        miso_d = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      rem_q  <= '0;
      miso_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      rem_q  <= rem_d;
      miso_q <= miso_d;
    end
  end

  assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: frame deserialiser, read-data handshake with timeout, MISO serialiser.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned TX_TIMEOUT = 15,
  parameter int unsigned CNT_W      = $clog2(DATA_W + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              tx_timeout,
  output logic              busy
);

  localparam int unsigned     TmoW    = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W + 1);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TX_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [DATA_W-1:0]  pay_q, pay_d;
  logic [DATA_W+1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               tx_timeout_q, tx_timeout_d;
  logic               rd_addr_done_q, rd_addr_done_d;
  logic               ser_load, ser_shift, ser_done;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tmo_d          = tmo_q;
    cmd_d          = cmd_q;
    pay_d          = pay_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    tx_timeout_d   = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    ser_load       = 1'b0;
    ser_shift      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!SS_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        if (SS_n) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else begin
          cmd_d = {MOSI, 1'b0};
          pay_d = '0;
          cnt_d = '0;
          if (!MOSI)               state_d = StWrite;
          else if (rd_addr_done_q) state_d = StReadData;
          else                     state_d = StReadAdd;
        end
      end
      StWrite, StReadAdd, StReadData: begin
        if (SS_n) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (cnt_q != LastBit) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0)   cmd_d[0] = MOSI;
          else if (LSB_FIRST) pay_d   = {MOSI, pay_q[DATA_W-1:1]};
          else                pay_d   = {pay_q[DATA_W-2:0], MOSI};
        end else begin
          rx_data_d  = {cmd_q, pay_q};
          rx_valid_d = 1'b1;
          if (state_q == StReadData) begin
            state_d = StRdWait;
            tmo_d   = '0;
          end else begin
            state_d = StDone;
            if (state_q == StReadAdd) rd_addr_done_d = 1'b1;
          end
        end
      end
      StRdWait: begin
        if (SS_n) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (tx_valid) begin
          ser_load = 1'b1;
          state_d  = StRdSend;
        end else if (tmo_q == TmoLast) begin
          tmo_d          = tmo_q + TmoW'(1);
          tx_timeout_d   = 1'b1;
          rd_addr_done_d = 1'b0;
          state_d        = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRdSend: begin
        if (SS_n) begin
          state_d        = StIdle;
          frame_err_d    = 1'b1;
          rd_addr_done_d = 1'b0;
        end else begin
          ser_shift = 1'b1;
          if (ser_done) begin
            rd_addr_done_d = 1'b0;
            state_d        = StDone;
          end
        end
      end
      StDone: begin
        if (SS_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      tmo_q          <= '0;
      cmd_q          <= '0;
      pay_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      tx_timeout_q   <= 1'b0;
      rd_addr_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      cmd_q          <= cmd_d;
      pay_q          <= pay_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      tx_timeout_q   <= tx_timeout_d;
      rd_addr_done_q <= rd_addr_done_d;
    end
  end

  // SS_n high forces MISO low in every state, covering aborts and DONE.
  spi_tx_serializer #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .clr_i   (SS_n),
    .data_i  (tx_data),
    .miso_o  (MISO),
    .done_o  (ser_done)
  );

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign tx_timeout = tx_timeout_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench: an 8-bit MSB-first instance and a 16-bit LSB-first instance.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mosi;
  logic        ss_a, ss_b;
  logic        tx_valid_a, tx_valid_b;
  logic [7:0]  tx_data_a;
  logic [15:0] tx_data_b;
  logic        miso_a, miso_b;
  logic [9:0]  rx_data_a;
  logic [17:0] rx_data_b;
  logic        rx_valid_a, rx_valid_b;
  logic        frame_err_a, frame_err_b;
  logic        tx_timeout_a, tx_timeout_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(15)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (ss_a),
    .MOSI       (mosi),
    .MISO       (miso_a),
    .rx_data    (rx_data_a),
    .rx_valid   (rx_valid_a),
    .tx_data    (tx_data_a),
    .tx_valid   (tx_valid_a),
    .frame_err  (frame_err_a),
    .tx_timeout (tx_timeout_a),
    .busy       (busy_a)
  );

  spi_slave_ctrl #(.DATA_W(16), .LSB_FIRST(1'b1), .TX_TIMEOUT(15)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (ss_b),
    .MOSI       (mosi),
    .MISO       (miso_b),
    .rx_data    (rx_data_b),
    .rx_valid   (rx_valid_b),
    .tx_data    (tx_data_b),
    .tx_valid   (tx_valid_b),
    .frame_err  (frame_err_b),
    .tx_timeout (tx_timeout_b),
    .busy       (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drops SS_n, takes the CHK_CMD entry edge, then clocks in all F frame bits.
  task automatic send(input bit sel, input logic [1:0] cmd, input logic [15:0] pay,
                      output int early, output int miso_hi);
    logic [17:0] seq;
    logic [15:0] rev;
    int          nbits;
    early   = 0;
    miso_hi = 0;
    for (int i = 0; i < 16; i++) rev[15-i] = pay[i];
    if (sel) begin
      seq   = {cmd, rev};
      nbits = 18;
      ss_b  = 1'b0;
    end else begin
      seq   = {cmd, pay[7:0], 8'h00};
      nbits = 10;
      ss_a  = 1'b0;
    end
    tick();
    for (int b = 0; b < nbits; b++) begin
      mosi = seq[17];
      seq  = seq << 1;
      tick();
      if ((sel ? rx_valid_b : rx_valid_a) !== 1'b0) early++;
      if ((sel ? miso_b : miso_a) !== 1'b0) miso_hi++;
    end
    mosi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          early, mhi, n;
    logic [7:0]  m8;
    logic [15:0] m16;

    rst_n = 1'b0; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_data_a = '0; tx_data_b = '0;
    tick(); tick();
    chk("rst_rx_data", rx_data_a, 10'h000);
    chk("rst_pulses", {rx_valid_a, frame_err_a, tx_timeout_a}, 3'b000);
    chk("rst_miso_busy", {miso_a, busy_a, miso_b, busy_b}, 4'b0000);
    rst_n = 1'b1;
    tick();

    // 1: write frame 0,0,A5
    send(1'b0, 2'b00, 16'h00A5, early, mhi);
    chk("t1_no_early_valid", early, 0);
    chk("t1_miso_low", mhi, 0);
    tick();
    chk("t1_rx_valid", rx_valid_a, 1'b1);
    chk("t1_rx_data", rx_data_a, 10'h0A5);
    chk("t1_state_done", dut_a.state_q, StDone);
    tick();
    chk("t1_single_pulse", rx_valid_a, 1'b0);
    ss_a = 1'b1;
    tick();
    chk("t1_idle_busy", busy_a, 1'b0);

    // 2: read-address then read-data with immediate tx_valid
    send(1'b0, 2'b10, 16'h003C, early, mhi);
    tick();
    chk("t2_addr_rx_data", rx_data_a, 10'h23C);
    chk("t2_addr_done_set", dut_a.rd_addr_done_q, 1'b1);
    ss_a = 1'b1;
    tick();
    tx_valid_a = 1'b1;
    tx_data_a  = 8'hC3;
    send(1'b0, 2'b11, 16'h005A, early, mhi);
    chk("t2_state_read_data", dut_a.state_q, StReadData);
    chk("t2_miso_low_in_frame", mhi, 0);
    tick();
    chk("t2_data_rx_data", {rx_valid_a, rx_data_a}, 11'h75A);
    tick();
    for (int k = 0; k < 8; k++) begin
      m8[7-k] = miso_a;
      tick();
    end
    chk("t2_miso_bits", m8, 8'hC3);
    chk("t2_miso_after", miso_a, 1'b0);
    chk("t2_state_done", dut_a.state_q, StDone);
    chk("t2_addr_done_clr", dut_a.rd_addr_done_q, 1'b0);
    tx_valid_a = 1'b0;
    ss_a = 1'b1;
    tick();

    // 3: read-data with tx_valid low -> timeout
    send(1'b0, 2'b10, 16'h0011, early, mhi);
    tick();
    ss_a = 1'b1;
    tick();
    send(1'b0, 2'b11, 16'h0022, early, mhi);
    tick();
    chk("t3_state_rd_wait", dut_a.state_q, StRdWait);
    n   = 0;
    mhi = 0;
    while (tx_timeout_a !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (miso_a !== 1'b0) mhi++;
    end
    chk("t3_timeout_cycles", n, 15);
    chk("t3_miso_low", mhi, 0);
    chk("t3_addr_done_clr", dut_a.rd_addr_done_q, 1'b0);
    tick();
    chk("t3_timeout_pulse", tx_timeout_a, 1'b0);
    ss_a = 1'b1;
    tick();
    tx_valid_a = 1'b1;
    tx_data_a  = 8'hFF;
    send(1'b0, 2'b11, 16'h0000, early, mhi);
    chk("t3_next_read_add", dut_a.state_q, StReadAdd);
    tick(); tick();
    chk("t3_no_send", {miso_a, dut_a.rd_addr_done_q}, 2'b01);
    tx_valid_a = 1'b0;
    ss_a = 1'b1;
    tick();

    // 4: abort a write frame after 5 bits
    ss_a = 1'b0;
    tick();
    m8 = 8'b0110_1000;
    for (int b = 0; b < 5; b++) begin
      mosi = m8[7];
      m8   = m8 << 1;
      tick();
    end
    mosi = 1'b0;
    ss_a = 1'b1;
    tick();
    chk("t4_frame_err", frame_err_a, 1'b1);
    chk("t4_no_valid_idle", {rx_valid_a, busy_a}, 2'b00);
    chk("t4_rx_data_held", rx_data_a, 10'h300);
    tick();
    chk("t4_err_pulse", frame_err_a, 1'b0);

    // 5: 16-bit LSB-first instance
    send(1'b1, 2'b01, 16'h1234, early, mhi);
    chk("t5_no_early_valid", early, 0);
    tick();
    chk("t5_rx_data", {rx_valid_b, rx_data_b}, 19'h51234);
    ss_b = 1'b1;
    tick();
    send(1'b1, 2'b10, 16'h0000, early, mhi);
    tick();
    ss_b = 1'b1;
    tick();
    tx_valid_b = 1'b1;
    tx_data_b  = 16'hBEEF;
    send(1'b1, 2'b11, 16'h0000, early, mhi);
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      m16[k] = miso_b;
      tick();
    end
    chk("t5_miso_lsb_first", m16, 16'hBEEF);
    chk("t5_state_done", dut_b.state_q, StDone);
    tx_valid_b = 1'b0;
    ss_b = 1'b1;
    tick();

    // 6: asynchronous reset during RD_SEND
    send(1'b0, 2'b10, 16'h0001, early, mhi);
    tick();
    ss_a = 1'b1;
    tick();
    tx_valid_a = 1'b1;
    tx_data_a  = 8'hFF;
    send(1'b0, 2'b11, 16'h0002, early, mhi);
    tick(); tick(); tick();
    chk("t6_sending", {dut_a.state_q, miso_a}, {StRdSend, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_immediate", {miso_a, busy_a, dut_a.rd_addr_done_q}, 3'b000);
    tick(); tick();
    chk("t6_no_pulses", {frame_err_a, tx_timeout_a, rx_valid_a}, 3'b000);
    tx_valid_a = 1'b0;
    ss_a  = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("t6_idle_after", busy_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
